// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode field, opcodes, NOP encoding, fetch FSM states.
package mips_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_JUMP  = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word (and its PC+4) that arrives while IF/ID is blocked.
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_flush,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pcp4,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic [31:0] o_pcp4
);

  logic        r_valid;
  logic [31:0] r_data;
  logic [31:0] r_pcp4;

  // Flush beats load so a word captured in a redirect cycle never survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= INSTR_NOP;
      r_pcp4  <= 32'h0;
    end else begin
      if (i_flush)
        r_valid <= 1'b0;
      else if (i_load)
        r_valid <= 1'b1;
      else if (i_drain)
        r_valid <= 1'b0;

      if (i_load && !i_flush) begin
        r_data <= i_data;
        r_pcp4 <= i_pcp4;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pcp4  = r_pcp4;

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: PC, imem request/ready handshake, skid buffer and IF/ID register.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ImemReq,
  output logic [31:0]         ImemAddr,
  input  logic                ImemReady,
  input  logic [31:0]         ImemData,
  input  logic                Stall,
  input  logic                Redirect,
  input  logic [31:0]         RedirectPC,
  output logic [31:0]         InstrOut,
  output logic [31:0]         PCPlus4Out,
  output logic [OPCODE_W-1:0] Opcode,
  output logic                InstrValid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]         FetchCount,
  output logic [31:0]         StallCount,
  output logic [31:0]         FlushCount
`endif
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  fetch_state_e r_state;
  logic         r_imem_req;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_addr;
  logic [31:0]  r_instr;
  logic [31:0]  r_pcp4;
  logic         r_valid;

  logic         w_blocked;
  logic         w_skid_load;
  logic         w_skid_drain;
  logic         w_skid_valid;
  logic [31:0]  w_skid_data;
  logic [31:0]  w_skid_pcp4;
  logic [31:0]  w_redirect_pc;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_req_plus4;

  assign w_blocked     = r_valid && Stall;
  assign w_redirect_pc = word_align(RedirectPC);
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_req_plus4   = r_req_addr + 32'd4;

  assign w_skid_load  = (r_state == FS_FETCH) && ImemReady && w_blocked && !Redirect;
  assign w_skid_drain = (r_state == FS_HOLD) && !Stall && w_skid_valid && !Redirect;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (Redirect),
    .i_data  (ImemData),
    .i_pcp4  (w_req_plus4),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_pcp4  (w_skid_pcp4)
  );

  // ImemReq/ImemAddr only change when a request completes or none is up, so a request is never withdrawn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FS_IDLE;
      r_imem_req <= 1'b0;
      r_pc       <= RESET_PC_ALIGNED;
      r_req_addr <= RESET_PC_ALIGNED;
      r_instr    <= INSTR_NOP;
      r_pcp4     <= 32'h0;
      r_valid    <= 1'b0;
    end else if (Redirect) begin
      r_valid <= 1'b0;
      r_pc    <= w_redirect_pc;
      unique case (r_state)
        FS_FETCH: begin
          if (ImemReady)
            r_req_addr <= w_redirect_pc;
          else
            r_state <= FS_DRAIN;
        end
        FS_DRAIN: begin
          if (ImemReady) begin
            r_state    <= FS_FETCH;
            r_req_addr <= w_redirect_pc;
          end
        end
        default: begin
          r_state    <= FS_FETCH;
          r_imem_req <= 1'b1;
          r_req_addr <= w_redirect_pc;
        end
      endcase
    end else begin
      unique case (r_state)
        FS_IDLE: begin
          r_state    <= FS_FETCH;
          r_imem_req <= 1'b1;
          r_req_addr <= r_pc;
        end
        FS_FETCH: begin
          if (ImemReady) begin
            r_pc <= w_pc_plus4;
            if (!w_blocked) begin
              r_instr    <= ImemData;
              r_pcp4     <= w_req_plus4;
              r_valid    <= 1'b1;
              r_req_addr <= w_pc_plus4;
            end else begin
              r_state    <= FS_HOLD;
              r_imem_req <= 1'b0;
            end
          end else if (!w_blocked) begin
            r_valid <= 1'b0;
          end
        end
        FS_HOLD: begin
          if (w_skid_drain) begin
            r_instr    <= w_skid_data;
            r_pcp4     <= w_skid_pcp4;
            r_valid    <= 1'b1;
            r_state    <= FS_FETCH;
            r_imem_req <= 1'b1;
            r_req_addr <= r_pc;
          end
        end
        FS_DRAIN: begin
          if (ImemReady) begin
            r_state    <= FS_FETCH;
            r_req_addr <= r_pc;
          end
        end
      endcase
    end
  end

  assign ImemReq    = r_imem_req;
  assign ImemAddr   = r_req_addr;
  assign InstrOut   = r_instr;
  assign PCPlus4Out = r_pcp4;
  assign Opcode     = r_instr[31:26];
  assign InstrValid = r_valid;

`ifdef IFU_PERF_CNT_EN
  logic        w_ifid_load;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  assign w_ifid_load = ((r_state == FS_FETCH) && ImemReady && !w_blocked && !Redirect) || w_skid_drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (w_ifid_load)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_blocked)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (Redirect)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign FetchCount = r_fetch_cnt;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the single-issue MIPS core. It produces the instruction stream that the control unit decodes. It owns the PC, drives a request/ready handshake to instruction memory, and holds the IF/ID register whose `Opcode` field feeds the decoder. It accepts redirects (taken BEQ, JUMP) and stalls from downstream, flushing or holding the fetched word as required.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ImemReq`  out  1  fetch request to instruction memory.
- `ImemAddr`  out  32  word-aligned fetch address; bits [1:0] are always 0.
- `ImemReady`  in  1  memory returns `ImemData` this cycle.
- `ImemData`  in  32  fetched instruction word; valid only when `ImemReady`=1.
- `Stall`  in  1  downstream cannot consume IF/ID this cycle.
- `Redirect`  in  1  taken branch or jump; flush and refetch.
- `RedirectPC`  in  32  new PC; bits [1:0] are ignored and forced to 0.
- `InstrOut`  out  32  IF/ID instruction.
- `PCPlus4Out`  out  32  IF/ID PC+4 of `InstrOut`.
- `Opcode`  out  6  `InstrOut[31:26]`, to the control unit.
- `InstrValid`  out  1  IF/ID holds a live instruction.

## Operation
- Internal registers:
  - `PC`: next address to request.
  - `ReqAddr`: address of the outstanding request. `ImemAddr` = `ReqAddr`.
  - Skid buffer: data word plus its PC+4.
  - FSM with states IDLE, FETCH, HOLD and DRAIN.
- Handshake rule: once raised, `ImemReq` stays high with `ImemAddr` stable until `ImemReady`=1. A request is never withdrawn.
- IF/ID "blocked" = `InstrValid` && `Stall`. An empty IF/ID always accepts new data.
- IDLE: `ImemReq`=0. Go to FETCH on the next edge.
- FETCH: `ImemReq`=1.
  - `ImemReady` and not blocked: load IF/ID with `ImemData` and PC+4, set `InstrValid`=1, PC += 4, start the next request at the new PC.
  - `ImemReady` and blocked: write `ImemData` and PC+4 into the skid buffer, PC += 4, go to HOLD.
  - No `ImemReady` and not blocked: `InstrValid` <= 0 (bubble).
  - No `ImemReady` and blocked: IF/ID holds.
- HOLD: `ImemReq`=0. IF/ID holds while blocked. When `Stall`=0, move the skid buffer into IF/ID and go to FETCH.
- Redirect has priority over Stall in every state.
  - Always: `InstrValid` <= 0, skid buffer discarded, PC <= {RedirectPC[31:2], 2'b00}.
  - FETCH with `ImemReady`=1: discard the data, go to FETCH; the next request uses the new PC.
  - FETCH with `ImemReady`=0: go to DRAIN; the old request stays up on `ReqAddr`.
  - HOLD: go to FETCH.
  - DRAIN: update PC only.
- DRAIN: `ImemReq`=1 on the old `ReqAddr`. On `ImemReady`, discard the data and go to FETCH.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - `ImemReq`=0.
  - `ImemAddr`=`RESET_PC`.
  - `InstrOut`=32'h0000_0000 (NOP).
  - `PCPlus4Out`=0.
  - `Opcode`=0.
  - `InstrValid`=0.
  - State IDLE, PC=`RESET_PC`.
- First request: `ImemReq` rises after the first edge following reset release.
- Latency: with a zero-wait memory (`ImemReady` in the request cycle), `InstrOut` is valid on the next edge. Throughput is 1 instruction per cycle.
- Redirect cost: with zero-wait memory, exactly 1 bubble after the redirect cycle. In DRAIN, add the remaining memory wait.
- Reset asserted mid-request: the FSM returns to IDLE immediately and the memory side must abandon the request.

## Configuration
- `IFU_PERF_CNT_EN` defined:
  - Adds output `FetchCount` (32): instructions loaded into IF/ID.
  - Adds output `StallCount` (32): cycles blocked.
  - Adds output `FlushCount` (32): redirect cycles.
  - All three reset to 0 and wrap at 2^32.
- `IFU_PERF_CNT_EN` undefined: these ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared package `mips_pkg`:
  - `OPCODE_W`=6.
  - Opcode constants: R-type 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100, JUMP 6'b000010, ADDI 6'b001000.
  - `INSTR_NOP`=32'h0.
  - Fetch state enum.
- Sub-module `fetch_skid_buffer`: one-entry holding register (data plus PC+4) with load, drain and flush controls.

## Test plan
- Zero-wait memory, `RESET_PC`=0, no stalls: `ImemAddr` reads 0, 4, 8, … on consecutive cycles. `InstrValid` is high from the 2nd request onward, and `PCPlus4Out` equals address + 4.
- `ImemReady` delayed 3 cycles: `ImemReq` and `ImemAddr` stay stable for 3 cycles, then the data appears in IF/ID on the edge after ready.
- `Stall` held 2 cycles while valid, with a word returning during the stall: the skid buffer captures it and `ImemReq`=0 in HOLD. After the stall, the IF/ID sequence has no loss and no duplicate.
- `Redirect`=1 with `RedirectPC`=32'h40 during an outstanding request (`ImemReady` low): DRAIN completes the old address and its data is discarded. The next request is 0x40 and `InstrValid` is 0 in between.
- `Redirect` and `Stall` asserted together in HOLD: flush wins, `InstrValid`=0, and the next request goes to `RedirectPC`. `RedirectPC`=32'h43 fetches 0x40.
- PC at 32'hFFFF_FFFC with zero-wait memory: the next `ImemAddr` is 0. Asserting `reset` mid-request forces `ImemReq`=0 and `InstrValid`=0 asynchronously.
